// File: rtl/key_event_decoder.sv
// PS/2 set-2 scan-byte parser, modifier tracker, ASCII translator and event FIFO.
// Define KEY_DEC_BREAK_EVT_EN to also queue key-release events (evt_break=1).
module key_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             scan_valid,
  input  logic [7:0]       scan_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_ascii,
  output logic [7:0]       evt_scan,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             caps_lock,
  output logic             shift_held,
  output logic             ctrl_held,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] key_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_e;

  typedef struct packed {
`ifdef KEY_DEC_BREAK_EVT_EN
    logic       brk;
`endif
    logic       ext;
    logic [7:0] scan;
    logic [7:0] ascii;
  } evt_t;

  // Translate a completed code using the modifier state from before this byte.
  function automatic logic [7:0] xlate(input logic [7:0] code, input logic ext,
                                       input logic shift, input logic caps);
    logic [7:0] ch;
    logic       letter;
    ch     = 8'h00;
    letter = 1'b0;
    if (!ext) begin
      letter = 1'b1;
      case (code)
        8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
        8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
        8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
        8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
        8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
        8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
        8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
        8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
        8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
        default: begin
          letter = 1'b0;
          case (code)
            8'h45: ch = shift ? 8'h29 : 8'h30;
            8'h16: ch = shift ? 8'h21 : 8'h31;
            8'h1E: ch = shift ? 8'h40 : 8'h32;
            8'h26: ch = shift ? 8'h23 : 8'h33;
            8'h25: ch = shift ? 8'h24 : 8'h34;
            8'h2E: ch = shift ? 8'h25 : 8'h35;
            8'h36: ch = shift ? 8'h5E : 8'h36;
            8'h3D: ch = shift ? 8'h26 : 8'h37;
            8'h3E: ch = shift ? 8'h2A : 8'h38;
            8'h46: ch = shift ? 8'h28 : 8'h39;
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            8'h0D: ch = 8'h09;
            8'h76: ch = 8'h1B;
            default: ch = 8'h00;
          endcase
        end
      endcase
    end
    if (letter && (shift ^ caps)) ch = ch - 8'h20;
    return ch;
  endfunction

  state_e            state_q, state_d;
  logic              shift_q, shift_d;
  logic              ctrl_q, ctrl_d;
  logic              caps_q, caps_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     fill_q, fill_d;
  evt_t              fifo_mem [FIFO_DEPTH];

  logic cmp_valid, cmp_ext, cmp_brk;
  logic is_shift, is_ctrl, is_caps, is_mod;
  logic push_req, push_ok, pop, full, ovf_set;
  evt_t new_evt, head;

  // Prefix parser: E0 always restarts an extended sequence; F0 only arms a
  // break from IDLE or EXT; every other byte completes a key.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    cmp_valid = 1'b0;
    cmp_ext   = 1'b0;
    cmp_brk   = 1'b0;
    if (scan_valid) begin
      if (scan_data == 8'hE0) begin
        state_d = S_EXT;
      end else if (scan_data == 8'hF0 && state_q == S_IDLE) begin
        state_d = S_BRK;
      end else if (scan_data == 8'hF0 && state_q == S_EXT) begin
        state_d = S_EXT_BRK;
      end else begin
        state_d   = S_IDLE;
        cmp_valid = 1'b1;
        cmp_ext   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        cmp_brk   = (state_q == S_BRK) || (state_q == S_EXT_BRK);
      end
    end
  end

  always_comb begin
    is_shift = !cmp_ext && (scan_data == 8'h12 || scan_data == 8'h59);
    is_ctrl  = (scan_data == 8'h14);
    is_caps  = !cmp_ext && (scan_data == 8'h58);
    is_mod   = is_shift || is_ctrl || is_caps;

    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    caps_d  = caps_q;
    if (cmp_valid && is_shift)            shift_d = !cmp_brk;
    if (cmp_valid && is_ctrl)             ctrl_d  = !cmp_brk;
    if (cmp_valid && is_caps && !cmp_brk) caps_d  = !caps_q;
  end

  always_comb begin
`ifdef KEY_DEC_BREAK_EVT_EN
    push_req    = cmp_valid && !is_mod;
    new_evt.brk = cmp_brk;
`else
    push_req    = cmp_valid && !is_mod && !cmp_brk;
`endif
    new_evt.ext   = cmp_ext;
    new_evt.scan  = scan_data;
    new_evt.ascii = xlate(scan_data, cmp_ext, shift_q, caps_q);

    full    = (fill_q == CW'(FIFO_DEPTH));
    pop     = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push_req && (!full || pop);
    ovf_set = push_req && full && !pop;

    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    fill_d   = fill_q + CW'(push_ok) - CW'(pop);

    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;

    cnt_d = (push_ok && !cmp_brk) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= S_IDLE;
      shift_q  <= 1'b0;
      ctrl_q   <= 1'b0;
      caps_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      ctrl_q   <= ctrl_d;
      caps_q   <= caps_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: storage is not reset; outputs are gated by evt_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= new_evt;
  end

  assign head       = fifo_mem[rd_ptr_q];
  assign evt_valid  = (fill_q != '0);
  assign evt_ascii  = evt_valid ? head.ascii : 8'h00;
  assign evt_scan   = evt_valid ? head.scan  : 8'h00;
  assign evt_ext    = evt_valid && head.ext;
`ifdef KEY_DEC_BREAK_EVT_EN
  assign evt_break  = evt_valid && head.brk;
`else
  assign evt_break  = 1'b0;
`endif
  assign caps_lock  = caps_q;
  assign shift_held = shift_q;
  assign ctrl_held  = ctrl_q;
  assign overflow   = ovf_q;
  assign key_count  = cnt_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed self-checking bench for key_event_decoder; head events are compared
// as {valid, ext, break, scan, ascii} against hand-computed values.
module tb_key_event_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clrn, scan_valid, evt_ready, ovf_clr;
  logic [7:0] scan_data;
  logic       evt_valid, evt_ext, evt_break, caps_lock, shift_held, ctrl_held, overflow;
  logic [7:0] evt_ascii, evt_scan, key_count;
  logic [18:0] head_v;

  int total = 0;
  int fails = 0;
  int exp_count = 0;

  key_event_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .scan_valid(scan_valid), .scan_data(scan_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ascii(evt_ascii),
    .evt_scan(evt_scan), .evt_ext(evt_ext), .evt_break(evt_break),
    .caps_lock(caps_lock), .shift_held(shift_held), .ctrl_held(ctrl_held),
    .overflow(overflow), .ovf_clr(ovf_clr), .key_count(key_count)
  );

  always #5 clk = ~clk;
  assign head_v = {evt_valid, evt_ext, evt_break, evt_scan, evt_ascii};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d fails=%0d", total, fails);
    $fatal(1);
  end

  // Stimulus helpers start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    scan_data = b; scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; scan_data = 8'h00;
  endtask

  task automatic pop_head();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; scan_valid = 1'b0; scan_data = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (head_v !== 19'h0) begin fails++; $display("FAIL reset_head got=%h exp=0", head_v); end
    total++; if ({caps_lock, shift_held, ctrl_held, overflow} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {caps_lock, shift_held, ctrl_held, overflow}); end
    total++; if (key_count !== 8'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", key_count); end
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_make_break();
    evt_ready = 1'b1;
    send_byte(8'h1C); exp_count++;
    total++; if (head_v !== {3'b100, 8'h1C, 8'h61}) begin fails++; $display("FAIL make_a got=%h exp=%h", head_v, {3'b100, 8'h1C, 8'h61}); end
    send_byte(8'hF0);
    total++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL make_popped got=%b exp=0", evt_valid); end
    send_byte(8'h1C);
`ifdef KEY_DEC_BREAK_EVT_EN
    total++; if (head_v !== {3'b101, 8'h1C, 8'h61}) begin fails++; $display("FAIL break_a got=%h exp=%h", head_v, {3'b101, 8'h1C, 8'h61}); end
    @(negedge clk);
`else
    total++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL break_dropped got=%b exp=0", evt_valid); end
`endif
    evt_ready = 1'b0;
    total++; if (key_count !== 8'(exp_count)) begin fails++; $display("FAIL make_count got=%0d exp=%0d", key_count, exp_count); end
  endtask

  task automatic test_shift();
    send_byte(8'h12);
    total++; if (shift_held !== 1'b1 || evt_valid !== 1'b0) begin fails++; $display("FAIL shift_set got=%b/%b exp=1/0", shift_held, evt_valid); end
    send_byte(8'h1C); exp_count++;
    send_byte(8'hF0); send_byte(8'h12);
    total++; if (shift_held !== 1'b0) begin fails++; $display("FAIL shift_clr got=%b exp=0", shift_held); end
    send_byte(8'h1C); exp_count++;
    total++; if (head_v !== {3'b100, 8'h1C, 8'h41}) begin fails++; $display("FAIL shift_upper got=%h exp=%h", head_v, {3'b100, 8'h1C, 8'h41}); end
    pop_head();
    total++; if (head_v !== {3'b100, 8'h1C, 8'h61}) begin fails++; $display("FAIL shift_lower got=%h exp=%h", head_v, {3'b100, 8'h1C, 8'h61}); end
    pop_head();
    total++; if (evt_valid !== 1'b0 || key_count !== 8'(exp_count)) begin fails++; $display("FAIL shift_drain got=%b/%0d exp=0/%0d", evt_valid, key_count, exp_count); end
  endtask

  task automatic test_caps();
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    total++; if (caps_lock !== 1'b1) begin fails++; $display("FAIL caps_on got=%b exp=1", caps_lock); end
    send_byte(8'h1C); exp_count++;
    send_byte(8'h12);
    send_byte(8'h1C); exp_count++;
    total++; if (head_v !== {3'b100, 8'h1C, 8'h41}) begin fails++; $display("FAIL caps_upper got=%h exp=%h", head_v, {3'b100, 8'h1C, 8'h41}); end
    pop_head();
    total++; if (head_v !== {3'b100, 8'h1C, 8'h61}) begin fails++; $display("FAIL caps_shift_lower got=%h exp=%h", head_v, {3'b100, 8'h1C, 8'h61}); end
    pop_head();
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    total++; if ({caps_lock, shift_held, evt_valid} !== 3'b000) begin fails++; $display("FAIL caps_off got=%b exp=000", {caps_lock, shift_held, evt_valid}); end
  endtask

  task automatic test_ext();
    send_byte(8'hE0); send_byte(8'h75); exp_count++;
    total++; if (head_v !== {3'b110, 8'h75, 8'h00}) begin fails++; $display("FAIL ext_key got=%h exp=%h", head_v, {3'b110, 8'h75, 8'h00}); end
    pop_head();
    send_byte(8'h1C); exp_count++;
    total++; if (head_v !== {3'b100, 8'h1C, 8'h61}) begin fails++; $display("FAIL ext_then_plain got=%h exp=%h", head_v, {3'b100, 8'h1C, 8'h61}); end
    pop_head();
    send_byte(8'hE0); send_byte(8'h14);
    total++; if (ctrl_held !== 1'b1 || evt_valid !== 1'b0) begin fails++; $display("FAIL ext_ctrl_set got=%b/%b exp=1/0", ctrl_held, evt_valid); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    total++; if (ctrl_held !== 1'b0 || evt_valid !== 1'b0) begin fails++; $display("FAIL ext_ctrl_clr got=%b/%b exp=0/0", ctrl_held, evt_valid); end
    send_byte(8'h14);
    total++; if (ctrl_held !== 1'b1) begin fails++; $display("FAIL ctrl_set got=%b exp=1", ctrl_held); end
    send_byte(8'hF0); send_byte(8'h14);
    total++; if (ctrl_held !== 1'b0 || key_count !== 8'(exp_count)) begin fails++; $display("FAIL ctrl_clr got=%b/%0d exp=0/%0d", ctrl_held, key_count, exp_count); end
  endtask

  task automatic test_keys();
    logic [7:0] codes [6];
    logic [7:0] chars [6];
    logic       shft  [6];
    codes = '{8'h16, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h05};
    chars = '{8'h31, 8'h21, 8'h20, 8'h0D, 8'h08, 8'h00};
    shft  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (shft[i]) send_byte(8'h12);
      send_byte(codes[i]); exp_count++;
      total++; if (head_v !== {3'b100, codes[i], chars[i]}) begin fails++; $display("FAIL key_map%0d got=%h exp=%h", i, head_v, {3'b100, codes[i], chars[i]}); end
      pop_head();
      if (shft[i]) begin send_byte(8'hF0); send_byte(8'h12); end
    end
    total++; if (key_count !== 8'(exp_count)) begin fails++; $display("FAIL keys_count got=%0d exp=%0d", key_count, exp_count); end
  endtask

  task automatic test_overflow();
    int n;
    logic [7:0] first_c, last_c;
    for (int i = 0; i < DEPTH; i++) begin send_byte(8'h16); exp_count++; end
    total++; if (overflow !== 1'b0 || evt_valid !== 1'b1) begin fails++; $display("FAIL ovf_fill got=%b/%b exp=0/1", overflow, evt_valid); end
    send_byte(8'h16);
    total++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    scan_data = 8'h16; scan_valid = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; ovf_clr = 1'b0;
    total++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_priority got=%b exp=1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0 || key_count !== 8'(exp_count)) begin fails++; $display("FAIL ovf_clr got=%b/%0d exp=0/%0d", overflow, key_count, exp_count); end
    scan_data = 8'h1C; scan_valid = 1'b1; evt_ready = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; evt_ready = 1'b0; exp_count++;
    total++; if (overflow !== 1'b0 || key_count !== 8'(exp_count)) begin fails++; $display("FAIL full_push_pop got=%b/%0d exp=0/%0d", overflow, key_count, exp_count); end
    n = 0; first_c = 8'h00; last_c = 8'h00;
    while (evt_valid && n < DEPTH + 4) begin
      if (n == 0) first_c = evt_ascii;
      last_c = evt_ascii;
      pop_head();
      n++;
    end
    total++; if (n != DEPTH) begin fails++; $display("FAIL drain_len got=%0d exp=%0d", n, DEPTH); end
    total++; if (first_c !== 8'h31 || last_c !== 8'h61) begin fails++; $display("FAIL drain_order got=%h..%h exp=31..61", first_c, last_c); end
  endtask

  task automatic test_reset_prefix();
    send_byte(8'hE0); send_byte(8'hF0);
    clrn = 1'b0;
    #1;
    total++; if (evt_valid !== 1'b0 || key_count !== 8'd0) begin fails++; $display("FAIL async_reset got=%b/%0d exp=0/0", evt_valid, key_count); end
    @(negedge clk);
    clrn = 1'b1; exp_count = 0;
    @(negedge clk);
    send_byte(8'h1C); exp_count++;
    total++; if (head_v !== {3'b100, 8'h1C, 8'h61}) begin fails++; $display("FAIL prefix_discard got=%h exp=%h", head_v, {3'b100, 8'h1C, 8'h61}); end
    pop_head();
  endtask

  task automatic test_count_wrap();
    evt_ready = 1'b1;
    while ((exp_count % 256) != 255) begin send_byte(8'h1C); exp_count++; end
    total++; if (key_count !== 8'd255) begin fails++; $display("FAIL count_255 got=%0d exp=255", key_count); end
    send_byte(8'h1C); exp_count++;
    total++; if (key_count !== 8'd0) begin fails++; $display("FAIL count_wrap got=%0d exp=0", key_count); end
    @(negedge clk);
    evt_ready = 1'b0;
    total++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL wrap_drain got=%b exp=0", evt_valid); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift();
    test_caps();
    test_ext();
    test_keys();
    test_overflow();
    test_reset_prefix();
    test_count_wrap();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the make-event counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clrn, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port scan_valid, input, 1, meaning scan_data holds one PS/2 set-2 byte this cycle; always accepted.
REQ-006 SHALL have port scan_data, input, 8, meaning the received scan byte.
REQ-007 SHALL have port evt_valid, output, 1, meaning the FIFO head is valid.
REQ-008 SHALL have port evt_ready, input, 1, meaning the consumer pops the head when evt_valid=1.
REQ-009 SHALL have port evt_ascii, output, 8, meaning the translated ASCII of the head, or 0x00 if unmapped.
REQ-010 SHALL have port evt_scan, output, 8, meaning the raw code of the head without prefixes.
REQ-011 SHALL have port evt_ext, output, 1, meaning the head was E0-prefixed.
REQ-012 SHALL have port evt_break, output, 1, meaning the head is a key release.
REQ-013 SHALL have ports caps_lock, shift_held and ctrl_held, each output, 1, meaning the current modifier state.
REQ-014 SHALL have port overflow, output, 1, meaning sticky: an event was dropped.
REQ-015 SHALL have port ovf_clr, input, 1, meaning clear overflow.
REQ-016 SHALL have port key_count, output, CNT_W, meaning the count of pushed make events, wrapping modulo 2^CNT_W.

Function
REQ-017 SHALL parse with FSM states IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (after E0 F0); F0 moves IDLE->BRK and EXT->EXT_BRK; E0 moves IDLE->EXT; any other byte completes a key and returns the FSM to IDLE.
REQ-018 SHALL handle E0 received in BRK, EXT or EXT_BRK by moving to EXT; all other bytes are discarded while scan_valid=0.
REQ-019 SHALL treat the modifiers as follows: non-ext 12/59 set shift_held on make and clear it on break; 14 (ext or not) sets and clears ctrl_held; non-ext 58 make toggles caps_lock and its break is ignored; modifier codes SHALL never be pushed to the FIFO.
REQ-020 SHALL map letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z; uppercase when shift_held XOR caps_lock.
REQ-021 SHALL map digits 45,16,1E,26,25,2E,36,3D,3E,46 to '0'-'9', and when shift_held to ')','!','@','#','$','%','^','&','*','('.
REQ-022 SHALL map 29 to 0x20, 5A to 0x0D, 66 to 0x08, 0D to 0x09 and 76 to 0x1B; every other code and every ext code SHALL give 0x00.
REQ-023 SHALL use the modifier state in effect before the completing byte when translating.
REQ-024 SHALL place a completed non-modifier key on evt_* the cycle after its final byte when the FIFO is empty (1-cycle latency).
REQ-025 SHALL pop when evt_valid&&evt_ready; a push when full SHALL be dropped and set overflow; push and pop in the same cycle when full SHALL accept both.
REQ-026 SHALL give ovf_clr priority lower than a same-cycle overflow set.
REQ-027 SHALL increment key_count only on a successful make push, wrapping to 0.

Reset
REQ-028 SHALL, while clrn=0, asynchronously force FSM=IDLE, FIFO empty, evt_valid=0, evt_ascii/evt_scan=0x00, evt_ext/evt_break=0, modifiers=0, overflow=0 and key_count=0.
REQ-029 SHALL discard any partially received prefix sequence on reset.

Configuration
REQ-030 SHALL push break events (evt_break=1, same translation) when KEY_DEC_BREAK_EVT_EN is defined, and otherwise discard breaks after the modifier update so that evt_break reads constant 0.

Verification
REQ-031 SHALL cover: 1C then F0 1C, ready=1 -> event 0x61 make; with macro, also 0x61 break; key_count=1.
REQ-032 SHALL cover: 12, 1C, F0 12, 1C -> 0x41 then 0x61; shift_held 1 then 0.
REQ-033 SHALL cover: 58, F0 58, 1C, 12, 1C -> caps_lock=1, events 0x41 then 0x61.
REQ-034 SHALL cover: E0 75 -> evt_ext=1, evt_scan=0x75, evt_ascii=0x00; a following 1C -> evt_ext=0.
REQ-035 SHALL cover: ready=0, FIFO_DEPTH+1 makes of 16 -> FIFO_DEPTH events held, overflow=1; ovf_clr -> 0; a full push+pop keeps the count.
REQ-036 SHALL cover: clrn low after E0 F0 -> a following 1C gives a non-ext make 0x61.
